mandel_frame_sequencer: RTL
===========================

// Module: mandel_frame_sequencer
// PURPOSE
//  Frame-level controller for the Mandelbrot iteration engine. Walks the image in raster order, top-left to bottom-right.
//  For each pixel it launches the engine and counts the engine's iteration pulses.
//  A pixel ends on divergence (|Z_n| > 2) or at MAX_ITER; the sequencer then hands a colour/address word to the frame-buffer writer.
//  Sits between the top-level frame trigger and the engine/frame-buffer pair.
// PARAMETERS
//  H_RES     160    pixels per row
//  V_RES     120    rows per frame
//  MAX_ITER  255    iteration budget per pixel; reaching it without divergence = in set
//  ITER_W    8      width of iteration count/colour; must hold MAX_ITER
//  ADDR_W    15     frame-buffer address width; must hold H_RES*V_RES-1
// PORTS
//  clk           in   1       system clock
//  rst           in   1       synchronous, active-high reset
//  start         in   1       begin a frame; honoured only in IDLE
//  stop          in   1       abandon frame; honoured in any non-IDLE state
//  busy          out  1       high from the cycle after accepted start until return to IDLE
//  frame_done    out  1       1-cycle pulse after the last pixel write is accepted
//  eng_start     out  1       1-cycle pulse: load eng_x/eng_y, begin iterating
//  eng_x         out  $clog2(H_RES)  current column, held stable while pixel in flight
//  eng_y         out  $clog2(V_RES)  current row, held stable while pixel in flight
//  eng_step      in   1       1-cycle pulse per completed iteration
//  eng_diverged  in   1       qualified by eng_step: this iteration exceeded |Z|>2
//  eng_abort     out  1       1-cycle pulse: engine returns to idle, discards state
//  pix_valid     out  1       pixel word valid for frame-buffer writer
//  pix_ready     in   1       writer accepts when pix_valid && pix_ready
//  pix_addr      out  ADDR_W  y*H_RES + x
//  pix_color     out  ITER_W  iteration count at divergence; 0 when in set
//  pix_in_set    out  1       1 = never diverged within MAX_ITER (drawn black)
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; x, y, addr, iter_cnt = 0. Reset mid-frame drops the pixel and frame; no pulses are emitted.
//  FSM: IDLE -> ISSUE -> RUN -> WRITE -> (ISSUE | DONE) -> IDLE.
//   IDLE: start=1 -> ISSUE; busy rises next cycle.
//   ISSUE: eng_start=1 for exactly one cycle; iter_cnt<=0; -> RUN.
//   RUN: each eng_step increments iter_cnt.
//    eng_step && eng_diverged: colour = iter_cnt+1, in_set=0, -> WRITE.
//    eng_step && iter_cnt+1 == MAX_ITER && !diverged: colour = 0, in_set=1, eng_abort pulse, -> WRITE.
//    Both on the same step: divergence wins (colour = MAX_ITER, in_set=0, no abort).
//   WRITE: pix_valid held with addr/colour/in_set stable until pix_ready.
//    On handshake: last pixel (x==H_RES-1, y==V_RES-1) -> DONE; else advance -> ISSUE.
//   DONE: frame_done=1 for one cycle; x, y, addr <= 0; -> IDLE.
//  Raster advance: x++; when x wraps H_RES-1 -> 0, y++. addr increments by 1 (no multiplier); all three clear together at frame end.
//  Latency: at least 1 cycle ISSUE->RUN, 1 cycle RUN->WRITE. With pix_ready tied high and a 1-step pixel, pixel period = 3 cycles.
//  stop: next cycle -> IDLE. eng_abort pulses if the state was RUN. No pix_valid, no frame_done; x, y, addr cleared.
//  stop beats start in the same cycle; start while busy is ignored.
//  eng_step outside RUN is ignored; iter_cnt saturates and never wraps.
// STRUCTURE
//  Package mandel_pkg: seq_state_e enum, default H_RES/V_RES/MAX_ITER constants, pixel word struct {addr, color, in_set}.
//  Sub-module raster_addr_gen: x/y/addr counters with advance, clear and last outputs. All else stays in one FSM file.
// TESTING
//  1 Reset then start; engine diverges on step 1 for every pixel -> 19200 writes, addr 0..19199 in order, colour=1, one frame_done.
//  2 Pixel (0,0) never diverges -> eng_abort after 255th step, pix_color=0, pix_in_set=1, addr=0.
//  3 Divergence on the 255th step -> colour=255, in_set=0, no eng_abort.
//  4 pix_ready low 5 cycles in WRITE -> pix_valid/addr/colour stable, no eng_start until handshake.
//  5 stop during RUN at pixel 37 -> eng_abort pulse, IDLE next cycle, no write; next start begins at addr 0.
//  6 start during busy; reset asserted mid-frame -> start ignored; all outputs 0 next cycle, no frame_done.

Source files
------------

// File: rtl/mandel_frame_sequencer_pkg.sv
// Shared types and default geometry for the Mandelbrot frame sequencer.
package mandel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RUN,
        ST_WRITE,
        ST_DONE
    } seq_state_e;

    localparam int DEF_H_RES    = 160;
    localparam int DEF_V_RES    = 120;
    localparam int DEF_MAX_ITER = 255;
    localparam int DEF_ITER_W   = 8;
    localparam int DEF_ADDR_W   = 15;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_ITER_W-1:0] color;
        logic                  in_set;
    } pix_word_t;

    // Counter width for a range of n values; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mandel_frame_sequencer_if.sv
// Control, engine and frame-buffer signals of the frame sequencer.
interface mandel_frame_sequencer_if #(
    parameter int X_W    = 8,
    parameter int Y_W    = 7,
    parameter int ITER_W = 8,
    parameter int ADDR_W = 15
);
    logic              start;
    logic              stop;
    logic              busy;
    logic              frame_done;
    logic              eng_start;
    logic [X_W-1:0]    eng_x;
    logic [Y_W-1:0]    eng_y;
    logic              eng_step;
    logic              eng_diverged;
    logic              eng_abort;
    logic              pix_valid;
    logic              pix_ready;
    logic [ADDR_W-1:0] pix_addr;
    logic [ITER_W-1:0] pix_color;
    logic              pix_in_set;

    // master: the sequencer; slave: trigger, engine and frame-buffer side.
    modport master (
        input  start, stop, eng_step, eng_diverged, pix_ready,
        output busy, frame_done, eng_start, eng_x, eng_y, eng_abort,
               pix_valid, pix_addr, pix_color, pix_in_set
    );

    modport slave (
        output start, stop, eng_step, eng_diverged, pix_ready,
        input  busy, frame_done, eng_start, eng_x, eng_y, eng_abort,
               pix_valid, pix_addr, pix_color, pix_in_set
    );
endinterface

// File: rtl/mandel_frame_sequencer_raster_addr_gen.sv
// Raster-order x/y/linear-address counters; address advances by increment only.
module raster_addr_gen #(
    parameter int H_RES  = 160,
    parameter int V_RES  = 120,
    parameter int X_W    = 8,
    parameter int Y_W    = 7,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    input  logic              clear,
    output logic [X_W-1:0]    x,
    output logic [Y_W-1:0]    y,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);
    logic x_end, y_end;

    assign x_end = (x == X_W'(H_RES - 1));
    assign y_end = (y == Y_W'(V_RES - 1));
    assign last  = x_end && y_end;

    always_ff @(posedge clk) begin
        if (rst || clear || (advance && last)) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (advance) begin
            addr <= addr + ADDR_W'(1);
            if (x_end) begin
                x <= '0;
                y <= y + Y_W'(1);
            end else begin
                x <= x + X_W'(1);
            end
        end
    end
endmodule

// File: rtl/mandel_frame_sequencer.sv
// Frame sequencer: walks pixels in raster order, runs the engine per pixel, emits colour words.
module mandel_frame_sequencer
    import mandel_pkg::*;
#(
    parameter int H_RES    = DEF_H_RES,
    parameter int V_RES    = DEF_V_RES,
    parameter int MAX_ITER = DEF_MAX_ITER,
    parameter int ITER_W   = DEF_ITER_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int X_W      = cnt_w(H_RES),
    parameter int Y_W      = cnt_w(V_RES)
) (
    input  logic                     clk,
    input  logic                     rst,
    mandel_frame_sequencer_if.master bus
);
    seq_state_e        state;
    logic [ITER_W-1:0] iter_cnt;
    logic [ITER_W-1:0] cnt_nxt;
    logic              busy_q, done_q, start_q, abort_q, valid_q, in_set_q;
    logic [ITER_W-1:0] color_q;
    logic              adv, clr, last;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [ADDR_W-1:0] addr;

    // Saturating so a stray extra step can never wrap the count.
    assign cnt_nxt = (iter_cnt == {ITER_W{1'b1}}) ? iter_cnt : iter_cnt + ITER_W'(1);

    always_comb begin
        adv = 1'b0;
        clr = 1'b0;
        if (state != ST_IDLE && bus.stop)
            clr = 1'b1;
        else if (state == ST_WRITE && bus.pix_ready && !last)
            adv = 1'b1;
        else if (state == ST_DONE)
            clr = 1'b1;
    end

    raster_addr_gen #(
        .H_RES (H_RES),
        .V_RES (V_RES),
        .X_W   (X_W),
        .Y_W   (Y_W),
        .ADDR_W(ADDR_W)
    ) u_raster (
        .clk    (clk),
        .rst    (rst),
        .advance(adv),
        .clear  (clr),
        .x      (x),
        .y      (y),
        .addr   (addr),
        .last   (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            iter_cnt <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            start_q  <= 1'b0;
            abort_q  <= 1'b0;
            valid_q  <= 1'b0;
            color_q  <= '0;
            in_set_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            abort_q <= 1'b0;
            done_q  <= 1'b0;
            if (state != ST_IDLE && bus.stop) begin
                state    <= ST_IDLE;
                busy_q   <= 1'b0;
                valid_q  <= 1'b0;
                iter_cnt <= '0;
                abort_q  <= (state == ST_RUN);
            end else begin
                case (state)
                    ST_IDLE: if (bus.start) begin
                        state   <= ST_ISSUE;
                        busy_q  <= 1'b1;
                        start_q <= 1'b1;
                    end
                    ST_ISSUE: begin
                        iter_cnt <= '0;
                        state    <= ST_RUN;
                    end
                    ST_RUN: if (bus.eng_step) begin
                        iter_cnt <= cnt_nxt;
                        // Divergence takes priority over the budget running out.
                        if (bus.eng_diverged) begin
                            color_q  <= cnt_nxt;
                            in_set_q <= 1'b0;
                            valid_q  <= 1'b1;
                            state    <= ST_WRITE;
                        end else if (cnt_nxt == ITER_W'(MAX_ITER)) begin
                            color_q  <= '0;
                            in_set_q <= 1'b1;
                            abort_q  <= 1'b1;
                            valid_q  <= 1'b1;
                            state    <= ST_WRITE;
                        end
                    end
                    ST_WRITE: if (bus.pix_ready) begin
                        valid_q <= 1'b0;
                        if (last) begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state   <= ST_ISSUE;
                            start_q <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;
    assign bus.eng_start  = start_q;
    assign bus.eng_abort  = abort_q;
    assign bus.eng_x      = x;
    assign bus.eng_y      = y;
    assign bus.pix_valid  = valid_q;
    assign bus.pix_addr   = addr;
    assign bus.pix_color  = color_q;
    assign bus.pix_in_set = in_set_q;
endmodule
